uart_echo_buffer: RTL

- Buffered, mode-selectable successor to the single-byte UART loopback controller.
- Sits between a uart_rx instance and a uart_tx instance. Accepts received bytes into a FIFO and replays them to the transmitter.
- Optional case folding and line-buffered (release-on-terminator) echo.
- Reports fill level, sticky overflow and a dropped-byte count, so bursts no longer lose data while the transmitter is busy.

---
 rtl/uart_pkg.sv | 37 +++
 rtl/uart_echo_buffer_fifo.sv | 65 ++++++
 rtl/uart_echo_buffer.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the UART echo buffer: mode encodings, TX FSM states
// and the ASCII values used for case folding and line termination.
package uart_pkg;

    // i_mode encodings; bit0 selects upper-casing, bit1 selects line buffering
    typedef enum logic [1:0] {
        MODE_ECHO       = 2'b00,
        MODE_UPPER      = 2'b01,
        MODE_LINE       = 2'b10,
        MODE_LINE_UPPER = 2'b11
    } mode_e;

    localparam int MODE_BIT_UPPER = 0;
    localparam int MODE_BIT_LINE  = 1;

    // Transmit sequencer states
    typedef enum logic [1:0] {
        TX_IDLE      = 2'b00,
        TX_LOAD      = 2'b01,
        TX_START     = 2'b10,
        TX_WAIT_DONE = 2'b11
    } tx_state_e;

    localparam logic [7:0] ASCII_CR      = 8'h0D;
    localparam logic [7:0] ASCII_LF      = 8'h0A;
    localparam logic [7:0] ASCII_LOWER_A = 8'h61;
    localparam logic [7:0] ASCII_LOWER_Z = 8'h7A;
    localparam logic [7:0] CASE_OFFSET   = 8'h20;

    // Map 'a'..'z' onto 'A'..'Z'; every other byte passes through untouched
    function automatic logic [7:0] fold_upper(input logic [7:0] b);
        if (b >= ASCII_LOWER_A && b <= ASCII_LOWER_Z)
            return b - CASE_OFFSET;
        return b;
    endfunction

endpackage

// File: rtl/uart_echo_buffer_fifo.sv
// Synchronous FIFO with registered read data. Pointers carry one extra wrap
// bit so that full and empty stay distinguishable. Pushes while full and pops
// while empty are ignored; fullness is judged on the state at cycle start.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_wr_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_rd_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_rd_data;
    logic [AW:0]      w_count;
    logic             w_full;
    logic             w_empty;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_count   = r_wr_ptr - r_rd_ptr;
    assign w_full    = (w_count == FULL_CNT);
    assign w_empty   = (w_count == '0);
    assign w_do_push = i_push & ~w_full;
    assign w_do_pop  = i_pop & ~w_empty;

    assign o_rd_data = r_rd_data;
    assign o_full    = w_full;
    assign o_empty   = w_empty;
    assign o_count   = w_count;

    // Storage array; contents need no reset since the pointers gate reads
    always_ff @(posedge i_clk) begin
        if (w_do_push)
            r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
    end

    // Pointer advance and registered read of the head entry
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_rd_data <= '0;
        end else begin
            if (w_do_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop) begin
                r_rd_ptr  <= r_rd_ptr + 1'b1;
                r_rd_data <= r_mem[r_rd_ptr[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/uart_echo_buffer.sv
// Buffered UART echo: accepts bytes from uart_rx into a FIFO, optionally
// upper-cases them and holds them until a line terminator, then replays the
// released bytes to uart_tx one at a time. Reports fill level and drops.
module uart_echo_buffer
    import uart_pkg::*;
#(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    FIFO_DEPTH = 16,
    parameter logic [DATA_WIDTH-1:0] TERM_CHAR  = DATA_WIDTH'(ASCII_CR),
    parameter int                    DROP_CNT_W = 8
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [1:0]                  i_mode,
    input  logic                        i_rx_data_valid,
    input  logic [DATA_WIDTH-1:0]       i_rx_byte,
    output logic                        o_rx_ready,
    output logic [DATA_WIDTH-1:0]       o_tx_byte,
    output logic                        o_tx_data_valid,
    input  logic                        i_tx_active,
    input  logic                        i_tx_done,
    input  logic                        i_clear_status,
    output logic [$clog2(FIFO_DEPTH):0] o_fill,
    output logic                        o_overflow,
    output logic [DROP_CNT_W-1:0]       o_drop_count,
    output logic                        o_idle
);

    localparam int          CW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    logic                  r_rx_ready;
    logic                  r_line_q;
    logic [CW-1:0]         r_commit;
    logic                  r_overflow;
    logic [DROP_CNT_W-1:0] r_drop_count;
    tx_state_e             r_state;
    logic [DATA_WIDTH-1:0] r_tx_byte;
    logic                  r_tx_valid;

    logic                  w_accept;
    logic                  w_push;
    logic                  w_drop;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    logic [CW-1:0]         w_count;
    logic [CW-1:0]         w_fill_next;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic                  w_line_mode;
    logic                  w_is_term;
    logic                  w_mode_fall;
    logic                  w_commit_all;

    // The ready pulse doubles as the guard: no sampling while it is high, so
    // uart_rx has a cycle to drop valid before the next byte can be taken.
    assign w_accept = i_rx_data_valid & ~r_rx_ready;
    assign w_push   = w_accept & ~w_full;
    assign w_drop   = w_accept & w_full;

    // Only released entries may leave; a non-zero commit count implies a
    // non-empty FIFO, so the pop never underflows.
    assign w_pop = (r_state == TX_IDLE) && (r_commit != '0) && !i_tx_active;

    generate
        if (DATA_WIDTH == 8) begin : g_fold
            assign w_wr_data = i_mode[MODE_BIT_UPPER] ? fold_upper(i_rx_byte) : i_rx_byte;
        end else begin : g_nofold
            assign w_wr_data = i_rx_byte;
        end
    endgenerate

    sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_push    (w_push),
        .i_wr_data (w_wr_data),
        .i_pop     (w_pop),
        .o_rd_data (w_rd_data),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_count   (w_count)
    );

    // Release rules: echo writes release themselves; in line mode a
    // terminator or a write that fills the FIFO (which would otherwise
    // deadlock) releases everything, as does leaving line mode.
    assign w_line_mode  = i_mode[MODE_BIT_LINE];
    assign w_is_term    = (i_rx_byte == TERM_CHAR);
    assign w_mode_fall  = r_line_q & ~w_line_mode;
    assign w_fill_next  = w_count + CW'(w_push) - CW'(w_pop);
    assign w_commit_all = w_mode_fall
                        | (w_push & w_line_mode & (w_is_term | (w_fill_next == FULL_CNT)));

    // RX handshake pulse and previous line-mode bit for fall detection
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rx_ready <= 1'b0;
            r_line_q   <= 1'b0;
        end else begin
            r_rx_ready <= w_accept;
            r_line_q   <= w_line_mode;
        end
    end

    // Count of FIFO entries eligible for transmission
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_commit <= '0;
        else if (w_commit_all)
            r_commit <= w_fill_next;
        else
            r_commit <= r_commit + CW'(w_push & ~w_line_mode) - CW'(w_pop);
    end

    // Sticky overflow and saturating drop counter; a drop beats a clear
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (i_clear_status)
                r_drop_count <= DROP_CNT_W'(1);
            else if (!(&r_drop_count))
                r_drop_count <= r_drop_count + 1'b1;
        end else if (i_clear_status) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end
    end

    // TX sequencer: pop, latch the read data, pulse start, wait for done
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= TX_IDLE;
            r_tx_byte  <= '0;
            r_tx_valid <= 1'b0;
        end else begin
            r_tx_valid <= 1'b0;
            case (r_state)
                TX_IDLE: begin
                    if (w_pop)
                        r_state <= TX_LOAD;
                end
                TX_LOAD: begin
                    r_tx_byte <= w_rd_data;
                    r_state   <= TX_START;
                end
                TX_START: begin
                    r_tx_valid <= 1'b1;
                    r_state    <= TX_WAIT_DONE;
                end
                TX_WAIT_DONE: begin
                    if (i_tx_done)
                        r_state <= TX_IDLE;
                end
                default: r_state <= TX_IDLE;
            endcase
        end
    end

    assign o_rx_ready      = r_rx_ready;
    assign o_tx_byte       = r_tx_byte;
    assign o_tx_data_valid = r_tx_valid;
    assign o_fill          = w_count;
    assign o_overflow      = r_overflow;
    assign o_drop_count    = r_drop_count;
    assign o_idle          = w_empty && (r_state == TX_IDLE);

endmodule
